// File: rtl/fft_frame_ctrl.sv
// Ping-pong capture of stereo audio into N-sample frames, and a sequencer that
// copies each completed frame into the FFT input memory and starts the FFT.
module fft_frame_ctrl #(
  parameter int N_LOG2 = 5,
  parameter bit BITREV = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              newsample,
  input  logic [23:0]       left,
  input  logic [23:0]       right,
  input  logic [1:0]        chan_sel,
  input  logic              fft_done,
  output logic              ld_we,
  output logic [N_LOG2-1:0] ld_addr,
  output logic [31:0]       ld_data,
  output logic              fft_start,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic              overrun,
  output logic [7:0]        overrun_count
);
  localparam int N = 1 << N_LOG2;

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

  // Both banks share one array; the bank select is the address MSB.
  logic [23:0]       r_mem [0:2*N-1];

  state_t            r_state;
  logic [N_LOG2-1:0] r_wptr;
  logic              r_wbank;
  logic              r_rbank;
  logic [1:0]        r_full;
  logic [N_LOG2:0]   r_cnt;
  logic              r_ld_we;
  logic [N_LOG2-1:0] r_ld_addr;
  logic [31:0]       r_ld_data;
  logic              r_fft_start;
  logic              r_busy;
  logic [15:0]       r_frame_cnt;
  logic              r_overrun;
  logic [7:0]        r_ovr_cnt;

  logic [23:0]       w_avg;
  logic              w_sum_unused;
  logic [23:0]       w_sample;
  logic              w_cap;
  logic              w_wrap;
  logic              w_other_full;
  logic              w_rd_en;
  logic              w_load_end;
  logic [N_LOG2-1:0] w_idx;
  logic [N_LOG2-1:0] w_idx_rev;
  logic [N_LOG2-1:0] w_ld_addr_next;
  logic [N_LOG2:0]   w_waddr;
  logic [N_LOG2:0]   w_raddr;
  logic [1:0]        w_full_next;

  // 25-bit sum keeps the carry so the halved average cannot overflow.
  assign {w_avg, w_sum_unused} = {left[23], left} + {right[23], right};

  always_comb begin
    case (chan_sel)
      2'b01:   w_sample = right;
      2'b10:   w_sample = w_avg;
      default: w_sample = left;
    endcase
  end

  assign w_cap        = newsample & enable;
  assign w_wrap       = w_cap & (&r_wptr);
  assign w_other_full = r_full[~r_wbank];
  assign w_rd_en      = (r_state == LOAD) && !r_cnt[N_LOG2];
  assign w_load_end   = (r_state == LOAD) && r_cnt[N_LOG2];
  assign w_idx        = r_cnt[N_LOG2-1:0];
  assign w_waddr      = {r_wbank, r_wptr};
  assign w_raddr      = {r_rbank, w_idx};

  genvar gi;
  generate
    for (gi = 0; gi < N_LOG2; gi++) begin : g_rev
      assign w_idx_rev[gi] = w_idx[N_LOG2-1-gi];
    end
  endgenerate

  assign w_ld_addr_next = BITREV ? w_idx_rev : w_idx;

  // Sequencer clear and capture set always target different banks.
  always_comb begin
    w_full_next = r_full;
    if (w_load_end) w_full_next[r_rbank] = 1'b0;
    if (w_wrap && !w_other_full) w_full_next[r_wbank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_cap) r_mem[w_waddr] <= w_sample;
  end

  // Registered read lands directly in the output data register.
  always_ff @(posedge clk) begin
    if (reset || !w_rd_en) r_ld_data <= '0;
    else                   r_ld_data <= {r_mem[w_raddr][23:8], 16'h0000};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_wbank   <= 1'b0;
      r_full    <= 2'b00;
      r_overrun <= 1'b0;
      r_ovr_cnt <= 8'd0;
    end else begin
      r_full <= w_full_next;
      if (w_cap) begin
        r_wptr <= r_wptr + N_LOG2'(1);
        if (w_wrap) begin
          if (w_other_full) begin
            r_overrun <= 1'b1;
            if (r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
          end else begin
            r_wbank <= ~r_wbank;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rbank     <= 1'b0;
      r_cnt       <= '0;
      r_ld_we     <= 1'b0;
      r_ld_addr   <= '0;
      r_fft_start <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_ld_we     <= 1'b0;
      r_ld_addr   <= '0;
      r_fft_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_full[r_rbank]) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (w_load_end) begin
            r_rbank     <= ~r_rbank;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_fft_start <= 1'b1;
            r_state     <= START;
          end else begin
            r_ld_we   <= 1'b1;
            r_ld_addr <= w_ld_addr_next;
            r_cnt     <= r_cnt + (N_LOG2+1)'(1);
          end
        end
        START: r_state <= WAIT;
        WAIT: begin
          if (fft_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ld_we         = r_ld_we;
  assign ld_addr       = r_ld_addr;
  assign ld_data       = r_ld_data;
  assign fft_start     = r_fft_start;
  assign busy          = r_busy;
  assign frame_count   = r_frame_cnt;
  assign overrun       = r_overrun;
  assign overrun_count = r_ovr_cnt;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: a 32-point linear instance and an
// 8-point bit-reversed instance, each checked against queued expected writes.
module tb_fft_frame_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-point instance
  logic        reset = 1'b1, enable = 1'b1, newsample = 1'b0, fft_done = 1'b0;
  logic [23:0] left = '0, right = '0;
  logic [1:0]  chan_sel = 2'b00;
  logic        ld_we, fft_start, busy, overrun;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;

  // 8-point bit-reversed instance
  logic        b_reset = 1'b1, b_newsample = 1'b0, b_fft_done = 1'b0;
  logic [23:0] b_left = '0;
  logic        b_ld_we, b_fft_start, b_busy, b_overrun;
  logic [2:0]  b_ld_addr;
  logic [31:0] b_ld_data;
  logic [15:0] b_frame_count;
  logic [7:0]  b_overrun_count;

  fft_frame_ctrl #(.N_LOG2(5), .BITREV(1'b0)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .newsample(newsample),
    .left(left), .right(right), .chan_sel(chan_sel), .fft_done(fft_done),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .fft_start(fft_start),
    .busy(busy), .frame_count(frame_count), .overrun(overrun),
    .overrun_count(overrun_count)
  );

  fft_frame_ctrl #(.N_LOG2(3), .BITREV(1'b1)) u_dut_br (
    .clk(clk), .reset(b_reset), .enable(1'b1), .newsample(b_newsample),
    .left(b_left), .right(24'h000000), .chan_sel(2'b00), .fft_done(b_fft_done),
    .ld_we(b_ld_we), .ld_addr(b_ld_addr), .ld_data(b_ld_data),
    .fft_start(b_fft_start), .busy(b_busy), .frame_count(b_frame_count),
    .overrun(b_overrun), .overrun_count(b_overrun_count)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t bexp_q[$];
  int   n_total = 0;
  int   n_bad = 0;
  int   br_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] pick(input logic [1:0] cs, input logic [23:0] l, input logic [23:0] r);
    int s;
    case (cs)
      2'b01: return r;
      2'b10: begin
        s = int'($signed(l)) + int'($signed(r));
        s = s >>> 1;
        return s[23:0];
      end
      default: return l;
    endcase
  endfunction

  task automatic push_raw(input int idx, input logic [31:0] d);
    exp_q.push_back('{addr: idx, data: d});
  endtask

  task automatic push_smp(input int idx, input logic [23:0] smp);
    exp_q.push_back('{addr: idx, data: {smp[23:8], 16'h0000}});
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r, input logic [1:0] cs, input logic en);
    @(posedge clk); #1;
    left = l; right = r; chan_sel = cs; enable = en; newsample = 1'b1;
    @(posedge clk); #1;
    newsample = 1'b0;
  endtask

  task automatic bsend(input logic [23:0] l);
    @(posedge clk); #1;
    b_left = l; b_newsample = 1'b1;
    @(posedge clk); #1;
    b_newsample = 1'b0;
  endtask

  task automatic done_pulse();
    @(posedge clk); #1 fft_done = 1'b1;
    @(posedge clk); #1 fft_done = 1'b0;
  endtask

  // Monitor for the 32-point instance
  int   n_start = 0, run_len = 0, last_run = 0, ld_since = 0;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ld_we === 1'b1) begin
      run_len++;
      ld_since++;
      check_val("ld_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("ld_addr", {27'b0, ld_addr}, e.addr);
        check_val("ld_data", ld_data, e.data);
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
      check_val("ld_idle_zero", {27'b0, ld_addr} | ld_data, 32'h0);
    end
    if (fft_start === 1'b1) begin
      n_start++;
      check_val("start_single", prev_start, 1'b0);
      check_val("frame_len", ld_since, 32);
      check_val("ld_run", last_run, 32);
      $display("frame start #%0d frame_count=%0d", n_start, frame_count);
      ld_since = 0;
    end
    prev_start = fft_start;
    if (reset) begin
      exp_q.delete();
      ld_since = 0;
      run_len = 0;
    end
  end

  // Monitor for the 8-point bit-reversed instance
  int   b_n_start = 0, b_ld_since = 0;
  logic b_prev_start = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (b_ld_we === 1'b1) begin
      b_ld_since++;
      check_val("b_ld_expected", bexp_q.size() != 0, 1'b1);
      if (bexp_q.size() != 0) begin
        e = bexp_q.pop_front();
        check_val("b_ld_addr", {29'b0, b_ld_addr}, e.addr);
        check_val("b_ld_data", b_ld_data, e.data);
      end
    end
    if (b_fft_start === 1'b1) begin
      b_n_start++;
      check_val("b_start_single", b_prev_start, 1'b0);
      check_val("b_frame_len", b_ld_since, 8);
      $display("bitrev frame start #%0d frame_count=%0d", b_n_start, b_frame_count);
      b_ld_since = 0;
    end
    b_prev_start = b_fft_start;
    if (b_reset) begin
      bexp_q.delete();
      b_ld_since = 0;
    end
  end

  task automatic wait_starts(input int target);
    for (int k = 0; k < 2000 && n_start < target; k++) @(negedge clk);
    check_val("start_seen", n_start, target);
  endtask

  task automatic bwait_starts(input int target);
    for (int k = 0; k < 2000 && b_n_start < target; k++) @(negedge clk);
    check_val("b_start_seen", b_n_start, target);
  endtask

  task automatic wait_busy(input logic level);
    for (int k = 0; k < 500 && busy !== level; k++) @(negedge clk);
    check_val("busy_wait", busy, level);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [23:0] l, r, s;
    logic [1:0]  cs;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ld_we", ld_we, 1'b0);
    check_val("rst_ld_addr", ld_addr, 5'd0);
    check_val("rst_ld_data", ld_data, 32'h0);
    check_val("rst_fft_start", fft_start, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_frame_count", frame_count, 16'd0);
    check_val("rst_overrun", overrun, 1'b0);
    check_val("rst_overrun_count", overrun_count, 8'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Ramp frame; fft_done while IDLE and during LOAD must be ignored
    for (int i = 0; i < 32; i++) begin
      push_raw(i, i << 16);
      if (i == 5) fft_done = 1'b1;
      send(24'(i << 8), 24'h0, 2'b00, 1'b1);
      fft_done = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1 fft_done = 1'b1;
    @(posedge clk); #1 fft_done = 1'b0;
    wait_starts(1);
    repeat (3) @(negedge clk);
    check_val("t1_frame_count", frame_count, 16'd1);
    check_val("t1_busy_in_wait", busy, 1'b1);
    done_pulse();
    wait_busy(1'b0);

    // Source selection, including the two fixed averaging cases
    for (int i = 0; i < 32; i++) begin
      if (i == 0) begin
        l = 24'h000100; r = 24'h000300; cs = 2'b10;
        push_raw(i, 32'h0002_0000);
      end else if (i == 1) begin
        l = 24'h800000; r = 24'h800000; cs = 2'b10;
        push_raw(i, 32'h8000_0000);
      end else begin
        l = 24'($urandom); r = 24'($urandom); cs = 2'($urandom_range(0, 3));
        push_smp(i, pick(cs, l, r));
      end
      send(l, r, cs, 1'b1);
    end
    wait_starts(2);
    check_val("t2_frame_count", frame_count, 16'd2);
    done_pulse();
    wait_busy(1'b0);

    // Reset during LOAD cycle 10
    for (int i = 0; i < 32; i++) begin
      s = 24'($urandom);
      push_smp(i, s);
      send(s, 24'h0, 2'b00, 1'b1);
    end
    wait_busy(1'b1);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_val("abort_ld_we", ld_we, 1'b0);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_frame_count", frame_count, 16'd0);
    check_val("abort_overrun_count", overrun_count, 8'd0);
    s0 = n_start;
    repeat (60) @(negedge clk);
    check_val("abort_no_start", n_start, s0);

    // Enable gating: 10 on, 5 strobes ignored, 22 on
    for (int i = 0; i < 37; i++) begin
      s = 24'($urandom);
      if (i < 10) begin push_smp(i, s); send(s, 24'h0, 2'b00, 1'b1); end
      else if (i < 15) send(s, 24'h0, 2'b00, 1'b0);
      else begin push_smp(i - 5, s); send(s, 24'h0, 2'b00, 1'b1); end
    end
    wait_starts(s0 + 1);
    check_val("t5_frame_count", frame_count, 16'd1);
    done_pulse();
    wait_busy(1'b0);

    // Overrun: frame 1 loaded, frame 2 pending, frame 3 discarded
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    s0 = n_start;
    for (int i = 0; i < 96; i++) begin
      s = 24'($urandom);
      if (i < 64) push_smp(i % 32, s);
      send(s, 24'h0, 2'b00, 1'b1);
      if (i == 63) check_val("ovr_before", overrun, 1'b0);
    end
    check_val("ovr_flag", overrun, 1'b1);
    check_val("ovr_count", overrun_count, 8'd1);
    check_val("ovr_frame_count", frame_count, 16'd1);
    check_val("ovr_starts", n_start, s0 + 1);
    done_pulse();
    wait_starts(s0 + 2);
    check_val("ovr_frame2_count", frame_count, 16'd2);
    check_val("ovr_queue_drained", exp_q.size(), 0);
    done_pulse();
    repeat (60) @(negedge clk);
    check_val("ovr_no_frame3", n_start, s0 + 2);
    check_val("ovr_idle", busy, 1'b0);

    // Bit-reversed instance: order, then overrun_count saturation
    @(posedge clk); #1 b_reset = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        s = 24'($urandom);
        bexp_q.push_back('{addr: br_tab[i], data: {s[23:8], 16'h0000}});
        bsend(s);
      end
    end
    bwait_starts(1);
    check_val("b_frame_count1", b_frame_count, 16'd1);
    check_val("b_no_overrun", b_overrun, 1'b0);
    for (int i = 0; i < 8; i++) bsend(24'($urandom));
    check_val("b_overrun_first", b_overrun, 1'b1);
    check_val("b_overrun_count1", b_overrun_count, 8'd1);
    for (int f = 0; f < 259; f++)
      for (int i = 0; i < 8; i++) bsend(24'($urandom));
    check_val("b_overrun_sat", b_overrun_count, 8'd255);
    check_val("b_overrun_sticky", b_overrun, 1'b1);
    check_val("b_frame_count_hold", b_frame_count, 16'd1);
    @(posedge clk); #1 b_fft_done = 1'b1;
    @(posedge clk); #1 b_fft_done = 1'b0;
    bwait_starts(2);
    check_val("b_frame_count2", b_frame_count, 16'd2);
    check_val("b_queue_drained", bexp_q.size(), 0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
